multi_player_game_fsm: RTL and testbench

MULTI_PLAYER_GAME_FSM -- requirements
Module: multi_player_game_fsm

---
 rtl/multi_player_game_fsm.sv | 195 +++++++++++++++++++
 tb/tb_multi_player_game_fsm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_player_game_fsm.sv
// Turn-based board game controller: dice-driven moves, event/back squares, per-roll timeout.
// Optional GAME_BOUNCE_BACK_EN: overshooting the goal bounces back instead of clamping.
module multi_player_game_fsm #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned GOAL_SQ     = 9,
  parameter logic [15:0] EVENT_MASK  = 16'h0154,
  parameter int unsigned BACK_SQ     = 3,
  parameter int unsigned SEC_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_S   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_btn,
  input  logic                     dice_valid,
  input  logic [1:0]               dice_value,
  input  logic                     event_end_tick,
  output logic [4*NUM_PLAYERS-1:0] pos_flat,
  output logic [1:0]               turn,
  output logic                     winner_valid,
  output logic [1:0]               winner_id,
  output logic [3:0]               event_flag,
  output logic                     event_valid,
  output logic [7:0]               time_led
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_EVENT = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_WIN   = 3'd6;

  localparam int unsigned CNT_W    = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(SEC_CYCLES - 1);
  localparam logic [3:0] GOAL      = 4'(GOAL_SQ);
  localparam logic [3:0] BACK      = 4'(BACK_SQ);
  localparam logic [3:0] TIMEOUT   = 4'(TIMEOUT_S);
  localparam logic [1:0] LAST_P    = 2'(NUM_PLAYERS - 1);
  localparam logic [7:0] LED_FULL  = 8'(8'hFF >> (8 - TIMEOUT_S));

  logic [2:0]               r_state;
  logic [2:0]               w_state_d;
  logic [4*NUM_PLAYERS-1:0] r_pos;
  logic [1:0]               r_turn;
  logic [1:0]               r_dice;
  logic [CNT_W-1:0]         r_sec_cnt;
  logic [3:0]               r_elapsed;
  logic [3:0]               r_flag;
  logic                     r_winner_valid;
  logic [1:0]               r_winner_id;

  logic [3:0] w_cur_pos;
  logic [4:0] w_sum;
  logic [3:0] w_new_pos;
  logic       w_roll_ok;
  logic       w_timeout;
  logic       w_is_back;
  logic       w_is_event;

  always_comb begin
    w_cur_pos = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (r_turn == 2'(p)) w_cur_pos = r_pos[4*p +: 4];
    end
  end

  // Five-bit sum so an overshoot past square 15 never wraps before clamping/bouncing.
  assign w_sum = {1'b0, w_cur_pos} + {3'b000, r_dice};

  always_comb begin
`ifdef GAME_BOUNCE_BACK_EN
    if (w_sum > {1'b0, GOAL}) begin
      w_new_pos = 4'(5'(2 * GOAL_SQ) - w_sum);
    end else begin
      w_new_pos = w_sum[3:0];
    end
`else
    if (w_sum >= {1'b0, GOAL}) begin
      w_new_pos = GOAL;
    end else begin
      w_new_pos = w_sum[3:0];
    end
`endif
  end

  assign w_roll_ok  = dice_valid && (dice_value != 2'd0);
  assign w_timeout  = (r_elapsed == TIMEOUT);
  assign w_is_back  = (BACK_SQ != 0) && (w_cur_pos == BACK);
  assign w_is_event = EVENT_MASK[w_cur_pos];

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      S_IDLE:  if (start_btn) w_state_d = S_WAIT;
      S_WAIT: begin
        if (w_timeout)      w_state_d = S_NEXT;
        else if (w_roll_ok) w_state_d = S_MOVE;
      end
      S_MOVE:  w_state_d = S_CHECK;
      S_CHECK: begin
        if (w_cur_pos == GOAL)       w_state_d = S_WIN;
        else if (w_is_back || w_is_event) w_state_d = S_EVENT;
        else                         w_state_d = S_NEXT;
      end
      S_EVENT: if (event_end_tick) w_state_d = S_NEXT;
      S_NEXT:  w_state_d = S_WAIT;
      S_WIN:   w_state_d = S_WIN;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pos          <= '0;
      r_turn         <= 2'd0;
      r_dice         <= 2'd0;
      r_sec_cnt      <= '0;
      r_elapsed      <= 4'd0;
      r_flag         <= 4'd0;
      r_winner_valid <= 1'b0;
      r_winner_id    <= 2'd0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        S_IDLE: begin
          if (start_btn) begin
            r_pos     <= '0;
            r_turn    <= 2'd0;
            r_sec_cnt <= '0;
            r_elapsed <= 4'd0;
            r_flag    <= 4'd0;
          end
        end
        S_WAIT: begin
          if (!w_timeout) begin
            if (w_roll_ok) r_dice <= dice_value;
            if (r_sec_cnt == SEC_LAST) begin
              r_sec_cnt <= '0;
              r_elapsed <= r_elapsed + 4'd1;
            end else begin
              r_sec_cnt <= r_sec_cnt + 1'b1;
            end
          end
        end
        S_MOVE: begin
          for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (r_turn == 2'(p)) r_pos[4*p +: 4] <= w_new_pos;
          end
        end
        S_CHECK: begin
          if (w_cur_pos == GOAL) begin
            r_winner_valid <= 1'b1;
            r_winner_id    <= r_turn;
            r_flag         <= 4'hF;
          end else if (w_is_back) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
              if (r_turn == 2'(p)) r_pos[4*p +: 4] <= 4'd0;
            end
            r_flag <= BACK;
          end else if (w_is_event) begin
            r_flag <= w_cur_pos;
          end else begin
            r_flag <= 4'd0;
          end
        end
        S_EVENT: if (event_end_tick) r_flag <= 4'd0;
        S_NEXT: begin
          r_turn    <= (r_turn == LAST_P) ? 2'd0 : r_turn + 2'd1;
          r_sec_cnt <= '0;
          r_elapsed <= 4'd0;
        end
        default: ;
      endcase
    end
  end

  // One LED per remaining second; fixed patterns before the game and after a win.
  always_comb begin
    case (r_state)
      S_IDLE:  time_led = 8'hFF;
      S_WIN:   time_led = 8'hAA;
      default: time_led = LED_FULL >> r_elapsed;
    endcase
  end

  assign pos_flat     = r_pos;
  assign turn         = r_turn;
  assign winner_valid = r_winner_valid;
  assign winner_id    = r_winner_id;
  assign event_flag   = r_flag;
  assign event_valid  = (r_state == S_EVENT);

endmodule

// File: tb/tb_multi_player_game_fsm.sv
// Directed bench for multi_player_game_fsm with 3 players and 10-cycle seconds.
// Expectations follow GAME_BOUNCE_BACK_EN when it is defined for the build.
module tb_multi_player_game_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_btn;
  logic        dice_valid;
  logic [1:0]  dice_value;
  logic        event_end_tick;
  logic [11:0] pos_flat;
  logic [1:0]  turn;
  logic        winner_valid;
  logic [1:0]  winner_id;
  logic [3:0]  event_flag;
  logic        event_valid;
  logic [7:0]  time_led;

  multi_player_game_fsm #(
    .NUM_PLAYERS (3),
    .GOAL_SQ     (9),
    .EVENT_MASK  (16'h0154),
    .BACK_SQ     (3),
    .SEC_CYCLES  (10),
    .TIMEOUT_S   (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_btn      (start_btn),
    .dice_valid     (dice_valid),
    .dice_value     (dice_value),
    .event_end_tick (event_end_tick),
    .pos_flat       (pos_flat),
    .turn           (turn),
    .winner_valid   (winner_valid),
    .winner_id      (winner_id),
    .event_flag     (event_flag),
    .event_valid    (event_valid),
    .time_led       (time_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        dv;
    logic [1:0]  dval;
    logic        eend;
    logic [11:0] pos;
    logic [1:0]  turn;
    logic [3:0]  flag;
    logic        ev;
    logic [7:0]  led;
  } vec_t;

  vec_t        tbl [14];
  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] e_pos;
  logic [1:0]  e_turn;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".pos"},  16'(pos_flat),     16'h000);
    chk({tag, ".turn"}, 16'(turn),         16'h0);
    chk({tag, ".wv"},   16'(winner_valid), 16'h0);
    chk({tag, ".wid"},  16'(winner_id),    16'h0);
    chk({tag, ".flag"}, 16'(event_flag),   16'h0);
    chk({tag, ".ev"},   16'(event_valid),  16'h0);
    chk({tag, ".led"},  16'(time_led),     16'hFF);
  endtask

  // One roll by the expected current player; sq is the hand-computed landing square.
  task automatic do_turn(input logic [1:0] val, input logic [3:0] sq, input logic [3:0] flag,
                         input bit hold);
    chk("turn.who", 16'(turn), 16'(e_turn));
    dice_valid = 1'b1;
    dice_value = val;
    step();
    dice_valid = 1'b0;
    dice_value = 2'd0;
    step();
    e_pos[4*e_turn +: 4] = sq;
    chk("turn.pos_move", 16'(pos_flat), 16'(e_pos));
    step();
    chk("turn.flag", 16'(event_flag), 16'(flag));
    chk("turn.ev", 16'(event_valid), 16'((flag != 4'h0) && (flag != 4'hF)));
    if (flag == 4'd3) e_pos[4*e_turn +: 4] = 4'd0;
    chk("turn.pos_chk", 16'(pos_flat), 16'(e_pos));
    if (flag == 4'hF || hold) return;
    if (flag != 4'h0) begin
      event_end_tick = 1'b1;
      step();
      event_end_tick = 1'b0;
      chk("turn.flag_clr", 16'(event_flag), 16'h0);
    end
    step();
    e_turn = (e_turn == 2'd2) ? 2'd0 : e_turn + 2'd1;
    chk("turn.next", 16'(turn), 16'(e_turn));
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 12'h000, 2'd0, 4'h0, 1'b0, 8'hFF};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 1'b0, 12'h000, 2'd0, 4'h0, 1'b0, 8'hFF};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h002, 2'd0, 4'h0, 1'b0, 8'hFF};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h002, 2'd0, 4'h2, 1'b1, 8'hFF};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 12'h002, 2'd0, 4'h2, 1'b1, 8'hFF};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 12'h002, 2'd0, 4'h2, 1'b1, 8'hFF};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b1, 12'h002, 2'd0, 4'h0, 1'b0, 8'hFF};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h002, 2'd1, 4'h0, 1'b0, 8'hFF};
    tbl[8]  = '{1'b0, 1'b1, 2'd0, 1'b1, 12'h002, 2'd1, 4'h0, 1'b0, 8'hFF};
    tbl[9]  = '{1'b0, 1'b1, 2'd3, 1'b0, 12'h002, 2'd1, 4'h0, 1'b0, 8'hFF};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h032, 2'd1, 4'h0, 1'b0, 8'hFF};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h002, 2'd1, 4'h3, 1'b1, 8'hFF};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b1, 12'h002, 2'd1, 4'h0, 1'b0, 8'hFF};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 12'h002, 2'd2, 4'h0, 1'b0, 8'hFF};

    reset = 1'b1;
    start_btn = 1'b0;
    dice_valid = 1'b0;
    dice_value = 2'd0;
    event_end_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      start_btn      = tbl[i].start;
      dice_valid     = tbl[i].dv;
      dice_value     = tbl[i].dval;
      event_end_tick = tbl[i].eend;
      step();
      chk($sformatf("vec%0d.pos", i),  16'(pos_flat),     16'(tbl[i].pos));
      chk($sformatf("vec%0d.turn", i), 16'(turn),         16'(tbl[i].turn));
      chk($sformatf("vec%0d.flag", i), 16'(event_flag),   16'(tbl[i].flag));
      chk($sformatf("vec%0d.ev", i),   16'(event_valid),  16'(tbl[i].ev));
      chk($sformatf("vec%0d.led", i),  16'(time_led),     16'(tbl[i].led));
      chk($sformatf("vec%0d.wv", i),   16'(winner_valid), 16'h0);
    end
    start_btn = 1'b0;
    dice_valid = 1'b0;
    dice_value = 2'd0;
    event_end_tick = 1'b0;

    // Timeout for player 2; a zero-valued strobe must not stop the timer.
    for (int k = 1; k <= 80; k++) begin
      dice_valid = (k == 5);
      step();
      dice_valid = 1'b0;
      chk($sformatf("tmo.led%0d", k), 16'(time_led), 16'(8'hFF >> (k / 10)));
    end
    step();
    chk("tmo.still_p2", 16'(turn), 16'h2);
    step();
    chk("tmo.wrap_turn", 16'(turn), 16'h0);
    chk("tmo.led_reload", 16'(time_led), 16'hFF);
    chk("tmo.pos_kept", 16'(pos_flat), 16'h002);

    e_pos = 12'h002;
    e_turn = 2'd0;
    do_turn(2'd3, 4'd5, 4'h0, 1'b0);
    do_turn(2'd1, 4'd1, 4'h0, 1'b0);
    do_turn(2'd1, 4'd1, 4'h0, 1'b0);
    do_turn(2'd3, 4'd8, 4'h8, 1'b0);
    do_turn(2'd3, 4'd4, 4'h4, 1'b0);
    do_turn(2'd3, 4'd4, 4'h4, 1'b0);
`ifdef GAME_BOUNCE_BACK_EN
    do_turn(2'd3, 4'd7, 4'h0, 1'b0);
    chk("bounce.wv", 16'(winner_valid), 16'h0);
    chk("bounce.pos", 16'(pos_flat), 16'h447);
`else
    do_turn(2'd3, 4'd9, 4'hF, 1'b0);
    chk("win.wv", 16'(winner_valid), 16'h1);
    chk("win.wid", 16'(winner_id), 16'h0);
    chk("win.led", 16'(time_led), 16'hAA);
    start_btn = 1'b1;
    dice_valid = 1'b1;
    dice_value = 2'd1;
    event_end_tick = 1'b1;
    repeat (3) step();
    start_btn = 1'b0;
    dice_valid = 1'b0;
    event_end_tick = 1'b0;
    chk("win.hold_pos", 16'(pos_flat), 16'h449);
    chk("win.hold_flag", 16'(event_flag), 16'hF);
    chk("win.hold_wv", 16'(winner_valid), 16'h1);
`endif

    // Fresh game, then reset while player 1 sits on square 6 in an event.
    reset = 1'b1;
    step();
    reset = 1'b0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    e_pos = 12'h000;
    e_turn = 2'd0;
    do_turn(2'd1, 4'd1, 4'h0, 1'b0);
    do_turn(2'd2, 4'd2, 4'h2, 1'b0);
    do_turn(2'd1, 4'd1, 4'h0, 1'b0);
    do_turn(2'd1, 4'd2, 4'h2, 1'b0);
    do_turn(2'd3, 4'd5, 4'h0, 1'b0);
    do_turn(2'd1, 4'd2, 4'h2, 1'b0);
    do_turn(2'd1, 4'd3, 4'h3, 1'b0);
    do_turn(2'd1, 4'd6, 4'h6, 1'b1);
    chk("mid.pos", 16'(pos_flat), 16'h260);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    step();
    reset = 1'b0;
    dice_valid = 1'b1;
    dice_value = 2'd2;
    event_end_tick = 1'b1;
    step();
    dice_valid = 1'b0;
    event_end_tick = 1'b0;
    repeat (3) step();
    chk_reset_vals("idle_after");
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    e_pos = 12'h000;
    e_turn = 2'd0;
    do_turn(2'd2, 4'd2, 4'h2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
